// File: rtl/song_pkg.sv
// Shared types, note codes and table-entry helpers for the song playback controller.
package song_pkg;

   localparam int ENTRY_W = 6;

   typedef logic [ENTRY_W-1:0] entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_C    = 4'd1;
   localparam logic [3:0] NOTE_CS   = 4'd2;
   localparam logic [3:0] NOTE_D    = 4'd3;
   localparam logic [3:0] NOTE_DS   = 4'd4;
   localparam logic [3:0] NOTE_E    = 4'd5;
   localparam logic [3:0] NOTE_F    = 4'd6;
   localparam logic [3:0] NOTE_FS   = 4'd7;
   localparam logic [3:0] NOTE_G    = 4'd8;
   localparam logic [3:0] NOTE_GS   = 4'd9;
   localparam logic [3:0] NOTE_A    = 4'd10;
   localparam logic [3:0] NOTE_AS   = 4'd11;
   localparam logic [3:0] NOTE_B    = 4'd12;

   function automatic entry_t make_entry(input logic [3:0] note, input logic [1:0] dur);
      return {note, dur};
   endfunction

   function automatic logic [3:0] entry_note(input entry_t e);
      return e[5:2];
   endfunction

   function automatic logic [1:0] entry_dur(input entry_t e);
      return e[1:0];
   endfunction

endpackage

// File: rtl/song_rom.sv
// Fixed note table for the music player. Each entry is {note, dur}; the note
// lasts dur+1 beats. Addresses at or beyond the song length read as a rest.
module song_rom
   import song_pkg::*;
#(
   parameter int SONG_LEN = 32
) (
   input  logic [4:0] addr_i,
   output entry_t     entry_o
);

   localparam logic [5:0] LEN = 6'(SONG_LEN);

   always_comb begin
      // NOTE: default assignment first keeps this block free of inferred latches.
      entry_o = make_entry(NOTE_REST, 2'd0);
      if ({1'b0, addr_i} < LEN) begin
         case (addr_i)
            5'd0:  entry_o = make_entry(NOTE_C,    2'd0);
            5'd1:  entry_o = make_entry(NOTE_E,    2'd1);
            5'd2:  entry_o = make_entry(NOTE_REST, 2'd0);
            5'd3:  entry_o = make_entry(NOTE_G,    2'd0);
            5'd4:  entry_o = make_entry(NOTE_A,    2'd1);
            5'd5:  entry_o = make_entry(NOTE_G,    2'd0);
            5'd6:  entry_o = make_entry(NOTE_F,    2'd0);
            5'd7:  entry_o = make_entry(NOTE_E,    2'd0);
            5'd8:  entry_o = make_entry(NOTE_D,    2'd1);
            5'd9:  entry_o = make_entry(NOTE_REST, 2'd0);
            5'd10: entry_o = make_entry(NOTE_CS,   2'd0);
            5'd11: entry_o = make_entry(NOTE_DS,   2'd0);
            5'd12: entry_o = make_entry(NOTE_FS,   2'd0);
            5'd13: entry_o = make_entry(NOTE_GS,   2'd0);
            5'd14: entry_o = make_entry(NOTE_AS,   2'd0);
            5'd15: entry_o = make_entry(NOTE_B,    2'd1);
            5'd16: entry_o = make_entry(NOTE_C,    2'd3);
            5'd17: entry_o = make_entry(NOTE_B,    2'd0);
            5'd18: entry_o = make_entry(NOTE_A,    2'd0);
            5'd19: entry_o = make_entry(NOTE_G,    2'd0);
            5'd20: entry_o = make_entry(NOTE_F,    2'd1);
            5'd21: entry_o = make_entry(NOTE_E,    2'd0);
            5'd22: entry_o = make_entry(NOTE_D,    2'd0);
            5'd23: entry_o = make_entry(NOTE_C,    2'd1);
            5'd24: entry_o = make_entry(NOTE_REST, 2'd1);
            5'd25: entry_o = make_entry(NOTE_E,    2'd0);
            5'd26: entry_o = make_entry(NOTE_G,    2'd0);
            5'd27: entry_o = make_entry(NOTE_E,    2'd0);
            5'd28: entry_o = make_entry(NOTE_D,    2'd1);
            5'd29: entry_o = make_entry(NOTE_B,    2'd0);
            5'd30: entry_o = make_entry(NOTE_D,    2'd0);
            5'd31: entry_o = make_entry(NOTE_C,    2'd3);
         endcase
      end
   end

endmodule

// File: rtl/song_ctrl.sv
// Playback controller: internal beat timebase, note-table sequencing and the
// play/pause/stop/loop/tempo FSM driving the downstream tone divider.
module song_ctrl
   import song_pkg::*;
#(
   parameter logic [31:0] DIV0     = 32'd3750000,
   parameter logic [31:0] DIV1     = 32'd2812500,
   parameter logic [31:0] DIV2     = 32'd5000000,
   parameter logic [31:0] DIV3     = 32'd7500000,
   parameter int          SONG_LEN = 32
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       play,
   input  logic       pause,
   input  logic       stop,
   input  logic       loop_en,
   input  logic [1:0] tempo_sel,
   output logic [3:0] note_code,
   output logic       note_valid,
   output logic [4:0] step_idx,
   output logic       beat_tick,
   output logic       busy,
   output logic       done
);

   localparam logic [4:0] LAST_IDX = 5'(SONG_LEN - 1);

   state_e      state_q;
   logic [31:0] count_q;
   logic [31:0] divn_act_q;
   logic [1:0]  beats_left_q;
   logic [4:0]  step_idx_q;
   logic [3:0]  note_code_q;
   logic        note_valid_q;
   logic        beat_tick_q;
   logic        busy_q;
   logic        done_q;

   logic [31:0] div_sel;
   logic [4:0]  rom_addr;
   entry_t      rom_entry;
   logic        tick;
   logic        last_entry;
   logic        song_end;

   always_comb begin
      case (tempo_sel)
         2'd0:    div_sel = DIV0;
         2'd1:    div_sel = DIV1;
         2'd2:    div_sel = DIV2;
         default: div_sel = DIV3;
      endcase
   end

   // The ROM is always addressed with the entry that would be loaded next.
   assign last_entry = (step_idx_q == LAST_IDX);
   assign rom_addr   = (state_q == ST_PLAY && !last_entry) ? step_idx_q + 5'd1 : 5'd0;
   assign tick       = (state_q == ST_PLAY) && (count_q >= divn_act_q);
   assign song_end   = tick && (beats_left_q == 2'd0) && last_entry && !loop_en;

   song_rom #(
      .SONG_LEN (SONG_LEN)
   ) u_rom (
      .addr_i  (rom_addr),
      .entry_o (rom_entry)
   );

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         divn_act_q   <= DIV0;
         beats_left_q <= '0;
         step_idx_q   <= '0;
         note_code_q  <= NOTE_REST;
         note_valid_q <= 1'b0;
         beat_tick_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // NOTE: pulses default low every cycle and are raised only where they fire.
         beat_tick_q <= 1'b0;
         done_q      <= 1'b0;
         if (stop) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            beats_left_q <= '0;
            step_idx_q   <= '0;
            note_code_q  <= NOTE_REST;
            note_valid_q <= 1'b0;
            busy_q       <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (play) begin
                     state_q      <= ST_PLAY;
                     step_idx_q   <= 5'd0;
                     note_code_q  <= entry_note(rom_entry);
                     beats_left_q <= entry_dur(rom_entry);
                     note_valid_q <= 1'b1;
                     busy_q       <= 1'b1;
                     count_q      <= 32'd1;
                     divn_act_q   <= div_sel;
                  end
               end
               ST_PLAY: begin
                  if (tick) begin
                     count_q     <= 32'd1;
                     beat_tick_q <= 1'b1;
                     divn_act_q  <= div_sel;
                     if (beats_left_q != 2'd0) begin
                        beats_left_q <= beats_left_q - 2'd1;
                     end else if (!song_end) begin
                        step_idx_q   <= rom_addr;
                        note_code_q  <= entry_note(rom_entry);
                        beats_left_q <= entry_dur(rom_entry);
                     end
                  end else begin
                     count_q <= count_q + 32'd1;
                  end
                  // Song end wins over a coincident pause; otherwise the tick completes first.
                  if (song_end) begin
                     state_q      <= ST_DONE;
                     done_q       <= 1'b1;
                     note_valid_q <= 1'b0;
                     busy_q       <= 1'b0;
                     step_idx_q   <= 5'd0;
                     note_code_q  <= NOTE_REST;
                     count_q      <= '0;
                  end else if (pause) begin
                     state_q      <= ST_PAUSE;
                     note_valid_q <= 1'b0;
                  end
               end
               ST_PAUSE: begin
                  if (play) begin
                     state_q      <= ST_PLAY;
                     note_valid_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign note_code  = note_code_q;
   assign note_valid = note_valid_q;
   assign step_idx   = step_idx_q;
   assign beat_tick  = beat_tick_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_song_ctrl.sv
// Scoreboard bench for song_ctrl: stimulus predicts every beat tick from the
// note table and tempo arithmetic; a monitor pops and compares on each tick.
module tb_song_ctrl;

   localparam int D0 = 4;
   localparam int D1 = 3;
   localparam int D2 = 6;
   localparam int D3 = 8;
   localparam int LEN = 4;

   logic       clkin;
   logic       rst_n;
   logic       play;
   logic       pause;
   logic       stop;
   logic       loop_en;
   logic [1:0] tempo_sel;
   logic [3:0] note_code;
   logic       note_valid;
   logic [4:0] step_idx;
   logic       beat_tick;
   logic       busy;
   logic       done;

   song_ctrl #(
      .DIV0     (32'(D0)),
      .DIV1     (32'(D1)),
      .DIV2     (32'(D2)),
      .DIV3     (32'(D3)),
      .SONG_LEN (LEN)
   ) dut (
      .clkin      (clkin),
      .rst_n      (rst_n),
      .play       (play),
      .pause      (pause),
      .stop       (stop),
      .loop_en    (loop_en),
      .tempo_sel  (tempo_sel),
      .note_code  (note_code),
      .note_valid (note_valid),
      .step_idx   (step_idx),
      .beat_tick  (beat_tick),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      int          cyc;
      logic [11:0] outs;
   } exp_t;

   int   tb_note [LEN] = '{1, 5, 0, 8};
   int   tb_dur  [LEN] = '{0, 1, 0, 0};
   int   beat_entry[$];
   int   total_beats;
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc;

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   always @(posedge clkin or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   function automatic int div_of(input int tsel);
      case (tsel)
         0:       return D0;
         1:       return D1;
         2:       return D2;
         default: return D3;
      endcase
   endfunction

   // Tick k lands d_first + (k-1)*d_rest cycles after the first PLAY cycle;
   // cycles spent paused push every later tick back by the pause length.
   task automatic expect_ticks(input int p, input int d_first, input int d_rest, input int n,
                               input bit lp, input int pa, input int pr);
      exp_t e;
      int   t;
      int   ent;
      bit   muted;
      for (int k = 1; k <= n; k++) begin
         t     = p + 1 + d_first + (k - 1) * d_rest;
         muted = 1'b0;
         if (pa >= 0 && t == pa + 1) muted = 1'b1;
         else if (pa >= 0 && t > pa + 1) t = t + (pr - pa);
         e.cyc = t;
         if (!lp && k == total_beats) begin
            e.outs = {5'd0, 4'd0, 1'b0, 1'b0, 1'b1};
         end else begin
            ent    = beat_entry[k % total_beats];
            e.outs = {5'(ent), 4'(tb_note[ent]), !muted, 1'b1, 1'b0};
         end
         sb_q.push_back(e);
      end
   endtask

   always @(negedge clkin) begin
      if (rst_n) begin
         if (done) check("done_with_tick", 32'(beat_tick), 32'd1);
         if (beat_tick) begin
            check("tick_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
               exp_t e;
               e = sb_q.pop_front();
               check("tick_cycle", 32'(cyc), 32'(e.cyc));
               check("tick_outputs", 32'({step_idx, note_code, note_valid, busy, done}), 32'(e.outs));
            end
         end
      end
   end

   task automatic goto(input int n);
      while (cyc < n) @(negedge clkin);
   endtask

   task automatic do_play();
      play = 1'b1;
      @(negedge clkin);
      play = 1'b0;
   endtask

   task automatic do_pause();
      pause = 1'b1;
      @(negedge clkin);
      pause = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      @(negedge clkin);
      stop = 1'b0;
   endtask

   task automatic check_idle(input string name);
      check(name, 32'({note_code, note_valid, step_idx, beat_tick, busy, done}), 32'd0);
   endtask

   task automatic drain(input int budget);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < budget) begin
         @(negedge clkin);
         #1;
         t++;
      end
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic run_song(input int tsel, input bit lp, input bit with_pause, input int n_loop);
      int p, d, n, a, r, kd, ent;
      tempo_sel = 2'(tsel);
      loop_en   = lp;
      d = div_of(tsel);
      n = lp ? n_loop : total_beats;
      p = cyc + int'($urandom_range(2, 5));
      a = -1;
      r = 0;
      if (with_pause) begin
         a = p + int'($urandom_range(2, 1 + 3 * d));
         r = a + int'($urandom_range(1, 20));
      end
      expect_ticks(p, d, d, n, lp, a, r);
      goto(p);
      do_play();
      check("start_entry", 32'({step_idx, note_code, note_valid, busy}),
            32'({5'd0, 4'(tb_note[0]), 1'b1, 1'b1}));
      if (with_pause) begin
         kd = 0;
         for (int k = 1; k <= n; k++) if (p + 1 + k * d <= a + 1) kd++;
         ent = beat_entry[kd % total_beats];
         goto(a);
         do_pause();
         for (int c = a + 1; c <= r; c++) begin
            goto(c);
            check("paused_state", 32'({step_idx, note_code, note_valid, busy}),
                  32'({5'(ent), 4'(tb_note[ent]), 1'b0, 1'b1}));
         end
         do_play();
         check("resume_valid", 32'(note_valid), 32'd1);
      end
      drain(400);
      if (lp) begin
         do_stop();
         check_idle("after_stop");
      end else begin
         goto(cyc + 1);
         check_idle("after_done");
      end
   endtask

   initial begin
      int p, t5, tsel;
      rst_n = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0;
      loop_en = 1'b0; tempo_sel = 2'd0;
      for (int i = 0; i < LEN; i++)
         for (int b = 0; b <= tb_dur[i]; b++) beat_entry.push_back(i);
      total_beats = beat_entry.size();
      @(negedge clkin);
      @(negedge clkin);
      rst_n = 1'b1;

      goto(3);
      check_idle("reset_state");
      goto(5);
      do_pause();
      check_idle("pause_in_idle");

      // Directed run: play at cycle 10, ticks 15..31, done at 31.
      expect_ticks(10, D0, D0, total_beats, 1'b0, -1, 0);
      goto(10);
      do_play();
      check("first_note", 32'({note_code, note_valid, step_idx}), 32'({4'd1, 1'b1, 5'd0}));
      drain(100);
      play = 1'b1;
      goto(cyc + 1);
      play = 1'b0;
      check_idle("play_in_done_ignored");
      goto(cyc + 1);
      check_idle("idle_after_done");

      run_song(0, 1'b1, 1'b0, 8);

      // Tempo 0 -> 3 mid-beat: first beat keeps DIV0, later beats use DIV3.
      tempo_sel = 2'd0;
      loop_en   = 1'b0;
      p = cyc + 2;
      expect_ticks(p, D0, D3, 4, 1'b0, -1, 0);
      goto(p);
      do_play();
      goto(p + 2);
      tempo_sel = 2'd3;
      drain(100);
      do_stop();
      check_idle("tempo_stop");

      // Stop in the same cycle as the final-beat tick: no tick, no done.
      tsel = int'($urandom_range(0, 3));
      tempo_sel = 2'(tsel);
      p  = cyc + 2;
      t5 = p + 1 + total_beats * div_of(tsel);
      expect_ticks(p, div_of(tsel), div_of(tsel), total_beats - 1, 1'b0, -1, 0);
      goto(p);
      do_play();
      goto(t5 - 1);
      do_stop();
      check_idle("stop_on_final_tick");
      goto(t5 + 3);
      check("no_late_events", 32'(sb_q.size()), 32'd0);

      // Asynchronous reset between clock edges while playing.
      tempo_sel = 2'd0;
      p = cyc + 2;
      goto(p);
      do_play();
      goto(p + 2);
      check("busy_before_reset", 32'({busy, note_valid}), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_reset");
      sb_q.delete();
      @(negedge clkin);
      rst_n = 1'b1;
      run_song(int'($urandom_range(0, 3)), 1'b0, 1'b0, 0);

      for (int i = 0; i < 8; i++) begin
         run_song(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(6, 10)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
